// File: rtl/serial_cmp_driver_if.sv
// serial_cmp_driver_if: control-side handshake plus bit-serial comparator link.
interface serial_cmp_driver_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic busy;
  logic done;
  logic L;
  logic E;
  logic G;
  logic cmp_clr;
  logic a_bit;
  logic b_bit;
  logic op;
  logic cmp_L;
  logic cmp_E;
  logic cmp_G;
  modport master (
    output start, A, B, cmp_L, cmp_E, cmp_G,
    input  busy, done, L, E, G, cmp_clr, a_bit, b_bit, op
  );
  modport slave (
    input  start, A, B, cmp_L, cmp_E, cmp_G,
    output busy, done, L, E, G, cmp_clr, a_bit, b_bit, op
  );
endinterface

// File: rtl/serial_cmp_driver.sv
// serial_cmp_driver: runs a bit-serial comparator as a start/done transaction unit.
module serial_cmp_driver #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic reset,
  serial_cmp_driver_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, HOLD, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      bus.cmp_clr <= 1'b0;
      bus.a_bit <= 1'b0;
      bus.b_bit <= 1'b0;
      bus.op <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.L <= 1'b0;
      bus.E <= 1'b0;
      bus.G <= 1'b0;
    end else begin
      bus.cmp_clr <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sa <= bus.A;
          sb <= bus.B;
          cnt <= '0;
          bus.cmp_clr <= 1'b1;
          bus.busy <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          bus.op <= 1'b0;
          bus.a_bit <= sa[WIDTH-1];
          bus.b_bit <= sb[WIDTH-1];
          state <= SHIFT;
        end
        SHIFT: begin
          // bit outputs are registered, so preload the MSB that follows the shift
          sa <= sa << 1;
          sb <= sb << 1;
          cnt <= cnt + 1'b1;
          bus.a_bit <= sa[WIDTH-2];
          bus.b_bit <= sb[WIDTH-2];
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt <= '0;
            bus.op <= 1'b1;
            bus.a_bit <= 1'b0;
            bus.b_bit <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          bus.L <= bus.cmp_L;
          bus.E <= bus.cmp_E;
          bus.G <= bus.cmp_G;
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
